// File: rtl/axi4_pkg.sv
// Shared constants, FSM state types and burst helpers for the AXI4 memory slave.
package axi4_pkg;

  // AXI response encodings
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  // Byte offset within a 4KB page; a burst may not run past this
  localparam logic [11:0] MASK_4K = 12'hFFF;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

  // Latched burst descriptor (address is held separately, its width is a parameter)
  typedef struct packed {
    logic [7:0] len;
    logic [2:0] size;
    logic       err;
  } burst_t;

  // True when the last beat of an INCR burst lands beyond the 4KB page of its start
  function automatic logic crosses_4k(input logic [11:0] start_lo,
                                      input logic [7:0]  len,
                                      input logic [2:0]  size);
    logic [15:0] end_lo;
    end_lo = 16'(start_lo) + (16'(len) << size);
    return end_lo > 16'(MASK_4K);
  endfunction

endpackage

// File: rtl/axi4_memory.sv
// Word-organised storage: one write port, one registered read port.
// The array itself is never reset; only the read-data register is.
module axi4_memory
  import axi4_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned MEMORY_DEPTH = 1024,
  parameter int unsigned ADDR_BITS    = $clog2(MEMORY_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [ADDR_BITS-1:0]  waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic                  rzero,
  input  logic [ADDR_BITS-1:0]  raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [MEMORY_DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  // Storage write port; contents survive reset
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  // Load a new read word (or zero for an errored burst) only when asked, else hold
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = rzero ? '0 : mem_q[raddr];
  end

  // Read-data register; a same-cycle write is not visible until the next read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi4_mem_slave.sv
// AXI4 memory slave: independent INCR-only write and read engines over a
// shared single-write/single-read word memory.
module axi4_mem_slave #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16,
  parameter int unsigned MEMORY_DEPTH = 1024
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic [ADDR_WIDTH-1:0] AWADDR,
  input  logic [7:0]            AWLEN,
  input  logic [2:0]            AWSIZE,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  WLAST,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic [7:0]            ARLEN,
  input  logic [2:0]            ARSIZE,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  RVALID,
  input  logic                  RREADY
);

  import axi4_pkg::*;

  localparam int unsigned BYTE_LSB = $clog2(DATA_WIDTH / 8);
  localparam int unsigned WORD_AW  = $clog2(MEMORY_DEPTH);

  // Descriptor is unusable if the beat is wider than the bus, it leaves its
  // 4KB page, or its last beat falls outside the storage
  function automatic logic desc_err(input logic [ADDR_WIDTH-1:0] start,
                                    input logic [7:0]            len,
                                    input logic [2:0]            size);
    logic [31:0] last_byte;
    last_byte = 32'(start) + (32'(len) << size);
    return (32'(size) > BYTE_LSB) ||
           crosses_4k(start[11:0], len, size) ||
           ((last_byte >> BYTE_LSB) >= 32'(MEMORY_DEPTH));
  endfunction

  function automatic logic [WORD_AW-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
    return WORD_AW'(addr >> BYTE_LSB);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] beat_step(input logic [2:0] size);
    return ADDR_WIDTH'(1) << size;
  endfunction

  // ---------------------------------------------------------------- write path
  w_state_e              w_state_q, w_state_d;
  logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
  burst_t                wdesc_q, wdesc_d;
  logic [7:0]            wbeat_q, wbeat_d;
  logic                  wlast_err_q, wlast_err_d;
  logic                  awready_q, awready_d;
  logic                  wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic                  aw_hs_c, w_hs_c, b_hs_c, w_final_c, wlast_bad_c;
  logic                  mem_we_c;
  logic [WORD_AW-1:0]    mem_waddr_c;

  assign aw_hs_c     = AWVALID && awready_q;
  assign w_hs_c      = WVALID && wready_q;
  assign b_hs_c      = BREADY && bvalid_q;
  assign w_final_c   = (wbeat_q == wdesc_q.len);
  assign wlast_bad_c = (WLAST != w_final_c);

  // Write FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) w_state_q <= W_IDLE;
    else        w_state_q <= w_state_d;
  end

  // Write FSM next state; the burst ends on beat count, not on WLAST
  always_comb begin
    w_state_d = w_state_q;
    case (w_state_q)
      W_IDLE:  if (aw_hs_c) w_state_d = W_DATA;
      W_DATA:  if (w_hs_c && w_final_c) w_state_d = W_RESP;
      W_RESP:  if (b_hs_c) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  // Write datapath, memory write strobe and next registered outputs
  always_comb begin
    waddr_d     = waddr_q;
    wdesc_d     = wdesc_q;
    wbeat_d     = wbeat_q;
    wlast_err_d = wlast_err_q;
    bresp_d     = bresp_q;
    mem_we_c    = 1'b0;
    mem_waddr_c = word_idx(waddr_q);

    if (aw_hs_c) begin
      waddr_d     = AWADDR;
      wdesc_d     = '{len: AWLEN, size: AWSIZE, err: desc_err(AWADDR, AWLEN, AWSIZE)};
      wbeat_d     = '0;
      wlast_err_d = 1'b0;
    end

    if (w_hs_c) begin
      mem_we_c = !wdesc_q.err;
      if (wlast_bad_c) wlast_err_d = 1'b1;
      if (w_final_c) begin
        bresp_d = (wdesc_q.err || wlast_err_q || wlast_bad_c) ? SLVERR : OKAY;
      end else begin
        waddr_d = waddr_q + beat_step(wdesc_q.size);
        wbeat_d = wbeat_q + 8'd1;
      end
    end

    awready_d = (w_state_d == W_IDLE);
    wready_d  = (w_state_d == W_DATA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Write datapath and output registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      waddr_q     <= '0;
      wdesc_q     <= '0;
      wbeat_q     <= '0;
      wlast_err_q <= 1'b0;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      bresp_q     <= OKAY;
    end else begin
      waddr_q     <= waddr_d;
      wdesc_q     <= wdesc_d;
      wbeat_q     <= wbeat_d;
      wlast_err_q <= wlast_err_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      bresp_q     <= bresp_d;
    end
  end

  // ----------------------------------------------------------------- read path
  r_state_e              r_state_q, r_state_d;
  logic [ADDR_WIDTH-1:0] raddr_q, raddr_d;
  burst_t                rdesc_q, rdesc_d;
  logic [7:0]            rbeat_q, rbeat_d;
  logic                  arready_q, arready_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [1:0]            rresp_q, rresp_d;

  logic                  ar_hs_c, r_hs_c, ar_err_c;
  logic                  mem_re_c, mem_rzero_c;
  logic [WORD_AW-1:0]    mem_raddr_c;

  assign ar_hs_c  = ARVALID && arready_q;
  assign r_hs_c   = RREADY && rvalid_q;
  assign ar_err_c = desc_err(ARADDR, ARLEN, ARSIZE);

  // Read FSM state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) r_state_q <= R_IDLE;
    else        r_state_q <= r_state_d;
  end

  // Read FSM next state
  always_comb begin
    r_state_d = r_state_q;
    case (r_state_q)
      R_IDLE:  if (ar_hs_c) r_state_d = R_DATA;
      R_DATA:  if (r_hs_c && rlast_q) r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  // Read datapath: fetch beat 0 at the AR handshake and each following beat as
  // the current one is accepted, so data is ready with RVALID; hold on stall
  always_comb begin
    raddr_d     = raddr_q;
    rdesc_d     = rdesc_q;
    rbeat_d     = rbeat_q;
    rlast_d     = rlast_q;
    rresp_d     = rresp_q;
    mem_re_c    = 1'b0;
    mem_rzero_c = rdesc_q.err;
    mem_raddr_c = word_idx(raddr_q);

    if (ar_hs_c) begin
      raddr_d     = ARADDR;
      rdesc_d     = '{len: ARLEN, size: ARSIZE, err: ar_err_c};
      rbeat_d     = '0;
      rlast_d     = (ARLEN == 8'd0);
      rresp_d     = ar_err_c ? SLVERR : OKAY;
      mem_re_c    = 1'b1;
      mem_rzero_c = ar_err_c;
      mem_raddr_c = word_idx(ARADDR);
    end else if (r_hs_c && !rlast_q) begin
      raddr_d     = raddr_q + beat_step(rdesc_q.size);
      rbeat_d     = rbeat_q + 8'd1;
      rlast_d     = ((rbeat_q + 8'd1) == rdesc_q.len);
      mem_re_c    = 1'b1;
      mem_raddr_c = word_idx(raddr_d);
    end

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read datapath and output registers
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      raddr_q   <= '0;
      rdesc_q   <= '0;
      rbeat_q   <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= OKAY;
    end else begin
      raddr_q   <= raddr_d;
      rdesc_q   <= rdesc_d;
      rbeat_q   <= rbeat_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
    end
  end

  // ------------------------------------------------------------------ storage
  axi4_memory #(
    .DATA_WIDTH  (DATA_WIDTH),
    .MEMORY_DEPTH(MEMORY_DEPTH),
    .ADDR_BITS   (WORD_AW)
  ) u_mem (
    .clk  (ACLK),
    .rst  (ARESET),
    .we   (mem_we_c),
    .waddr(mem_waddr_c),
    .wdata(WDATA),
    .re   (mem_re_c),
    .rzero(mem_rzero_c),
    .raddr(mem_raddr_c),
    .rdata(RDATA)
  );

  assign AWREADY = awready_q;
  assign WREADY  = wready_q;
  assign BVALID  = bvalid_q;
  assign BRESP   = bresp_q;
  assign ARREADY = arready_q;
  assign RVALID  = rvalid_q;
  assign RLAST   = rlast_q;
  assign RRESP   = rresp_q;

endmodule

// File: doc/axi4_mem_slave.md
AXI4_MEM_SLAVE -- requirements
Module: axi4_mem_slave

Interface
REQ-001 The block SHALL have these parameters:
- DATA_WIDTH, 32, data bus width in bits.
- ADDR_WIDTH, 16, byte address width.
- MEMORY_DEPTH, 1024, number of DATA_WIDTH words of storage.

REQ-002 The block SHALL have these ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_WIDTH  write burst start byte address.
- AWLEN  in  8  write beats minus 1.
- AWSIZE  in  3  log2 bytes per beat.
- AWVALID / AWREADY  in / out  1  write address handshake.
- WDATA  in  DATA_WIDTH  write data.
- WLAST  in  1  final write beat.
- WVALID / WREADY  in / out  1  write data handshake.
- BRESP  out  2  write response.
- BVALID / BREADY  out / in  1  write response handshake.
- ARADDR / ARLEN / ARSIZE  in  ADDR_WIDTH / 8 / 3  read burst descriptor.
- ARVALID / ARREADY  in / out  1  read address handshake.
- RDATA  out  DATA_WIDTH  read data.
- RRESP  out  2  read response.
- RLAST  out  1  final read beat.
- RVALID / RREADY  out / in  1  read data handshake.

Function
REQ-003 The block SHALL support INCR bursts only; beat address = start + beat_index * (1<<SIZE); word index = byte address >> log2(DATA_WIDTH/8).
REQ-004 The write FSM SHALL have states W_IDLE, W_DATA, W_RESP.
- W_IDLE: AWREADY=1; on AW handshake, latch descriptor and go to W_DATA.
- W_DATA: WREADY=1; on each W handshake, store one beat; after beat AWLEN+1, go to W_RESP.
- W_RESP: BVALID=1 with BRESP held stable; on BREADY go to W_IDLE.
REQ-005 The write burst SHALL end on beat count AWLEN+1 regardless of WLAST; WLAST low on the final beat, or high on any earlier beat, SHALL force BRESP=SLVERR.
REQ-006 A burst SHALL be flagged in error at the address handshake if any of these hold:
- SIZE > log2(DATA_WIDTH/8);
- start[11:0] + (LEN<<SIZE) > 12'hFFF (crosses a 4KB boundary);
- the last beat word index >= MEMORY_DEPTH.
REQ-007 An errored write SHALL suppress all memory writes of that burst and return BRESP=SLVERR (2'b10); otherwise BRESP=OKAY (2'b00).
REQ-008 The read FSM SHALL have states R_IDLE and R_DATA.
- R_IDLE: ARREADY=1; on AR handshake, latch descriptor and go to R_DATA.
- R_DATA: RVALID=1.
- RDATA, RRESP and RLAST SHALL be held stable while RVALID && !RREADY.
- On the R handshake of beat ARLEN+1, return to R_IDLE.
REQ-009 The first RVALID SHALL appear in the cycle after the AR handshake; with RREADY held high, beats SHALL be back-to-back, one per cycle.
REQ-010 RLAST SHALL be 1 only on beat ARLEN+1; errored reads SHALL return RDATA=0 and RRESP=SLVERR on every beat.
REQ-011 The read and write paths SHALL operate concurrently; a same-cycle read and write of the same word SHALL return the old data.
REQ-012 AWVALID/ARVALID SHALL NOT be accepted while the corresponding FSM is not idle (READY low).

Reset
REQ-013 ARESET high SHALL immediately force W_IDLE and R_IDLE and these output values:
- AWREADY=0, WREADY=0, BVALID=0, BRESP=0;
- ARREADY=0, RVALID=0, RDATA=0, RRESP=0, RLAST=0.
REQ-014 In the first cycle after ARESET deasserts, the block SHALL drive AWREADY=1 and ARREADY=1.
REQ-015 Memory contents SHALL NOT be reset.
REQ-016 A reset mid-burst SHALL abort the burst; words already written SHALL remain written.

Structure
REQ-017 Package axi4_pkg SHALL hold:
- response constants OKAY=2'b00 and SLVERR=2'b10;
- write and read FSM state enums;
- the 4KB mask constant.
REQ-018 Storage SHALL be a sub-module axi4_memory: one write port and one read port, with MEMORY_DEPTH x DATA_WIDTH words and a registered read.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- AW addr=0x0010, len=3, size=2; W beats 0xA0..0xA3 with WLAST on beat 4 -> BRESP=OKAY. AR of the same descriptor -> RDATA 0xA0..0xA3, RLAST on beat 4 only.
- AW addr=0x0FF8, len=3, size=2 (4KB cross) -> no memory writes, BRESP=SLVERR. Readback of 0x0FF8 returns its prior value.
- AR addr=0x1000 (word 1024, out of range), len=0 -> RDATA=0, RRESP=SLVERR, RLAST=1.
- Write len=1 with WLAST on beat 1 -> BRESP=SLVERR, and both beats are still consumed.
- RREADY toggled 1,0,0,1 during a 4-beat read -> RDATA, RRESP and RLAST stable while stalled, no beat lost.
- ARESET asserted during beat 2 of a 4-beat write -> all outputs 0 immediately; AWREADY=1 in the first cycle after release.
